// File: rtl/eclair_exec_core.sv
// ECLair execution core: loadable up-counter, 16-bit 74181-style ALU and
// 3-to-8 active-low decoder. The counter is the only sequential element.
module eclair_exec_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  input  logic [2:0]       dec_sel,
  output logic [7:0]       dec_n,
  input  logic             alu_mode,
  input  logic [3:0]       alu_op,
  input  logic             c_in,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  output logic [15:0]      z,
  output logic             c_out
);

  logic [WIDTH-1:0] count_q;

  // Reset beats load, load beats count enable.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= preset;
    end else if (ce) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

  assign dec_n = ~(8'b0000_0001 << dec_sel);

  logic [16:0] a17;
  logic [16:0] b17;
  logic [16:0] nb17;
  logic [16:0] ones17;
  logic [16:0] f;
  logic [16:0] r;
  logic [15:0] logic_z;

  assign a17    = {1'b0, x};
  assign b17    = {1'b0, y};
  assign nb17   = {1'b0, ~y};
  assign ones17 = 17'h0_FFFF;

  always_comb begin
    logic_z = 16'h0000;
    unique case (alu_op)
      4'h0: logic_z = ~x;
      4'h1: logic_z = ~(x | y);
      4'h2: logic_z = ~x & y;
      4'h3: logic_z = 16'h0000;
      4'h4: logic_z = ~(x & y);
      4'h5: logic_z = ~y;
      4'h6: logic_z = x ^ y;
      4'h7: logic_z = x & ~y;
      4'h8: logic_z = ~x | y;
      4'h9: logic_z = ~(x ^ y);
      4'hA: logic_z = y;
      4'hB: logic_z = x & y;
      4'hC: logic_z = 16'hFFFF;
      4'hD: logic_z = x | ~y;
      4'hE: logic_z = x | y;
      4'hF: logic_z = x;
      default: logic_z = 16'h0000;
    endcase
  end

  // All arithmetic is 17 bits wide so intermediate carries reach c_out.
  always_comb begin
    f = 17'h0_0000;
    unique case (alu_op)
      4'h0: f = a17;
      4'h1: f = a17 | b17;
      4'h2: f = a17 | nb17;
      4'h3: f = ones17;
      4'h4: f = a17 + (a17 & nb17);
      4'h5: f = (a17 | b17) + (a17 & nb17);
      4'h6: f = a17 + nb17;
      4'h7: f = (a17 & nb17) + ones17;
      4'h8: f = a17 + (a17 & b17);
      4'h9: f = a17 + b17;
      4'hA: f = (a17 | nb17) + (a17 & b17);
      4'hB: f = (a17 & b17) + ones17;
      4'hC: f = a17 + a17;
      4'hD: f = (a17 | b17) + a17;
      4'hE: f = (a17 | nb17) + a17;
      4'hF: f = a17 + ones17;
      default: f = 17'h0_0000;
    endcase
    r = f + {16'h0000, c_in};
  end

  assign z     = alu_mode ? logic_z : r[15:0];
  assign c_out = alu_mode ? 1'b0 : r[16];

endmodule

// File: tb/tb_eclair_exec_core.sv
// Directed self-checking bench for eclair_exec_core (counter at WIDTH=8).
module tb_eclair_exec_core;

  logic        clk;
  logic        _reset;
  logic        ce;
  logic        load;
  logic [7:0]  preset;
  logic [7:0]  count;
  logic [2:0]  dec_sel;
  logic [7:0]  dec_n;
  logic        alu_mode;
  logic [3:0]  alu_op;
  logic        c_in;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        c_out;

  int n_cmp;
  int n_err;

  eclair_exec_core #(.WIDTH(8)) dut (
    .clk      (clk),
    ._reset   (_reset),
    .ce       (ce),
    .load     (load),
    .preset   (preset),
    .count    (count),
    .dec_sel  (dec_sel),
    .dec_n    (dec_n),
    .alu_mode (alu_mode),
    .alu_op   (alu_op),
    .c_in     (c_in),
    .x        (x),
    .y        (y),
    .z        (z),
    .c_out    (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic m, input logic [3:0] op, input logic ci,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] ez, input logic ec, input string tag);
    alu_mode = m;
    alu_op   = op;
    c_in     = ci;
    x        = a;
    y        = b;
    #1;
    check({tag, "_z"}, {16'h0, z}, {16'h0, ez});
    check({tag, "_c"}, {31'h0, c_out}, {31'h0, ec});
  endtask

  logic [7:0] dec_exp [8];

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    _reset   = 1'b0;
    ce       = 1'b0;
    load     = 1'b0;
    preset   = 8'h00;
    dec_sel  = 3'd0;
    alu_mode = 1'b0;
    alu_op   = 4'h0;
    c_in     = 1'b0;
    x        = 16'h0000;
    y        = 16'h0000;

    // Counter: reset, count five, hold.
    #2;
    tick();
    check("reset", {24'h0, count}, 32'h0);
    _reset = 1'b1;
    ce     = 1'b1;
    repeat (5) tick();
    check("count5", {24'h0, count}, 32'h5);
    ce = 1'b0;
    repeat (3) tick();
    check("hold", {24'h0, count}, 32'h5);

    // Load beats ce, then wrap.
    load   = 1'b1;
    ce     = 1'b1;
    preset = 8'hFE;
    tick();
    check("load_fe", {24'h0, count}, 32'hFE);
    load = 1'b0;
    tick();
    check("cnt_ff", {24'h0, count}, 32'hFF);
    tick();
    check("wrap_00", {24'h0, count}, 32'h00);
    load   = 1'b1;
    preset = 8'h5A;
    ce     = 1'b0;
    tick();
    check("load_noce", {24'h0, count}, 32'h5A);
    _reset = 1'b0;
    load   = 1'b1;
    preset = 8'h33;
    ce     = 1'b1;
    tick();
    check("reset_over_load", {24'h0, count}, 32'h0);
    _reset = 1'b1;
    load   = 1'b0;
    ce     = 1'b0;

    // Decoder sweep.
    dec_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    for (int i = 0; i < 8; i++) begin
      dec_sel = 3'(i);
      #1;
      check($sformatf("dec%0d", i), {24'h0, dec_n}, {24'h0, dec_exp[i]});
    end

    // Arithmetic.
    alu(1'b0, 4'h9, 1'b0, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, "add");
    alu(1'b0, 4'h9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "add_carry");
    alu(1'b0, 4'h6, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, "sub");
    alu(1'b0, 4'h5, 1'b0, 16'hF0F0, 16'hFF00, 16'h00E0, 1'b1, "or_plus_andn");
    alu(1'b0, 4'hF, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, "dec_zero");
    alu(1'b0, 4'hF, 1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b1, "minus1_cin");
    alu(1'b0, 4'h3, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b1, "ones_cin");

    // Logic.
    alu(1'b1, 4'hB, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, "and");
    alu(1'b1, 4'hE, 1'b0, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, "or");
    alu(1'b1, 4'h6, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, "xor");
    alu(1'b1, 4'h0, 1'b0, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, "nota");
    alu(1'b1, 4'h3, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0, "zero_c0");
    alu(1'b1, 4'h3, 1'b1, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0, "zero_c1");
    alu(1'b1, 4'h9, 1'b1, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, "xnor");
    alu(1'b1, 4'hA, 1'b0, 16'hF0F0, 16'hFF00, 16'hFF00, 1'b0, "passb");
    alu(1'b1, 4'h7, 1'b0, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, "andnb");
    alu(1'b1, 4'hD, 1'b0, 16'hF0F0, 16'hFF00, 16'hF0FF, 1'b0, "ornb");

    // Pass-through and doubling.
    alu(1'b0, 4'h0, 1'b0, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, "pass");
    alu(1'b0, 4'h0, 1'b1, 16'hABCD, 16'h0000, 16'hABCE, 1'b0, "pass_inc");
    alu(1'b0, 4'hC, 1'b0, 16'h8001, 16'h0000, 16'h0002, 1'b1, "double");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
